top_level: RTL and testbench

Bit-serial radix-2 Booth multiplier with serial-in/serial-out valid/ready handshakes. Accepts two DATA_WIDTH-bit operands one bit per cycle, LSB first, and computes their 2×DATA_WIDTH-bit product with one Booth step per cycle. It then streams the product out LSB first. It is the top of the mult_booth block, sitting between a serializing producer and a deserializing consumer.

---
 rtl/top_level.sv | 154 +++++++++++++++
 tb/tb_top_level.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_level.sv
// Bit-serial radix-2 Booth multiplier: serial operand load, one Booth step per cycle, serial product out.
// Define BOOTH_SIGNED_EN to treat operands as two's complement (sign-extended Booth operands).
module top_level #(
    parameter int DATA_WIDTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_din_a,
    input  logic i_din_b,
    input  logic i_valid,
    input  logic i_ready,
    output logic o_ready,
    output logic o_prod,
    output logic o_valid
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(2 * W + 1);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0] LAST_LOAD = CW'(W - 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(W);
    localparam logic [CW-1:0] LAST_BIT  = CW'(2 * W);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        VALID,
        SEND
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [W-1:0]     opA_q;
    logic [W-1:0]     opB_q;
    logic [W:0]       m_q;
    logic [W:0]       acc_q;
    logic [W:0]       q_q;
    logic             qm1_q;
    logic [2*W-1:0]   prod_q;
    logic             oReady_q;
    logic             oValid_q;
    logic             oProd_q;

    logic [W-1:0]     opA_d;
    logic [W-1:0]     opB_d;
    logic [W:0]       mLoad_d;
    logic [W:0]       qLoad_d;
    logic [W:0]       boothSum_d;
    logic [2*W-1:0]   result_d;

    // Operand view including the bit arriving this edge, so the last bit can seed the Booth registers directly.
    always_comb begin
        opA_d = opA_q;
        opB_d = opB_q;
        opA_d[cnt_q[IW-1:0]] = i_din_a;
        opB_d[cnt_q[IW-1:0]] = i_din_b;
`ifdef BOOTH_SIGNED_EN
        mLoad_d = {opA_d[W-1], opA_d};
        qLoad_d = {opB_d[W-1], opB_d};
`else
        mLoad_d = {1'b0, opA_d};
        qLoad_d = {1'b0, opB_d};
`endif
        case ({q_q[0], qm1_q})
            2'b01:   boothSum_d = acc_q + m_q;
            2'b10:   boothSum_d = acc_q - m_q;
            default: boothSum_d = acc_q;
        endcase
        result_d = {acc_q[W-2:0], q_q};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            prod_q   <= '0;
            oReady_q <= 1'b1;
            oValid_q <= 1'b0;
            oProd_q  <= 1'b0;
        end else if (i_en) begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        opA_q <= opA_d;
                        opB_q <= opB_d;
                        if (cnt_q == LAST_LOAD) begin
                            cnt_q    <= '0;
                            m_q      <= mLoad_d;
                            q_q      <= qLoad_d;
                            acc_q    <= '0;
                            qm1_q    <= 1'b0;
                            oReady_q <= 1'b0;
                            state_q  <= CALC;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                // Add/subtract then arithmetic shift of {Acc, Q, q_m1}; W+1 steps cover the extended operand.
                CALC: begin
                    acc_q <= {boothSum_d[W], boothSum_d[W:1]};
                    q_q   <= {boothSum_d[0], q_q[W:1]};
                    qm1_q <= q_q[0];
                    if (cnt_q == LAST_STEP) begin
                        cnt_q    <= '0;
                        oValid_q <= 1'b1;
                        state_q  <= VALID;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                VALID: begin
                    if (i_ready) begin
                        oValid_q <= 1'b0;
                        oProd_q  <= result_d[0];
                        prod_q   <= {1'b0, result_d[2*W-1:1]};
                        cnt_q    <= CNT_ONE;
                        state_q  <= SEND;
                    end
                end
                // The stream cannot stall: i_ready is deliberately not looked at here.
                SEND: begin
                    if (cnt_q == LAST_BIT) begin
                        oProd_q  <= 1'b0;
                        oReady_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end else begin
                        oProd_q <= prod_q[0];
                        prod_q  <= {1'b0, prod_q[2*W-1:1]};
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = oReady_q;
    assign o_valid = oValid_q;
    assign o_prod  = oProd_q;

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: randomized serial words checked every cycle against a behavioural model.
// Build with BOOTH_SIGNED_EN defined to exercise the signed configuration.
module tb_top_level;

    localparam int W  = 4;
    localparam int PW = 2 * W;

`ifdef BOOTH_SIGNED_EN
    localparam logic [PW-1:0] LIT_FF = 8'h01;
    localparam logic [PW-1:0] LIT_9A = 8'h2A;
    localparam logic [PW-1:0] LIT_87 = 8'hC8;
`else
    localparam logic [PW-1:0] LIT_FF = 8'hE1;
    localparam logic [PW-1:0] LIT_9A = 8'h5A;
    localparam logic [PW-1:0] LIT_87 = 8'h38;
`endif

    logic i_clk   = 1'b0;
    logic i_rst   = 1'b1;
    logic i_en    = 1'b1;
    logic i_din_a = 1'b0;
    logic i_din_b = 1'b0;
    logic i_valid = 1'b0;
    logic i_ready = 1'b0;
    logic o_ready;
    logic o_prod;
    logic o_valid;

    int compared   = 0;
    int mismatched = 0;

    int            timeoutCount = 0;
    logic [PW-1:0] litExp       = '0;
    bit            litValid     = 1'b0;

    int            phase;
    int            nBits;
    int            calcLeft;
    int            sendIdx;
    int            strobePos;
    int            seenTimeouts;
    bit            strobe;
    logic [W-1:0]  mA;
    logic [W-1:0]  mB;
    logic [PW-1:0] mProd;
    logic [PW-1:0] gotWord;
    logic          expReady;
    logic          expValid;
    logic          expProd;

    top_level #(.DATA_WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_din_a (i_din_a),
        .i_din_b (i_din_b),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_ready (o_ready),
        .o_prod  (o_prod),
        .o_valid (o_valid)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [PW-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        sa = longint'(a);
        sb = longint'(b);
`ifdef BOOTH_SIGNED_EN
        if (a[W-1]) sa = sa - (longint'(1) << W);
        if (b[W-1]) sb = sb - (longint'(1) << W);
`endif
        return PW'(sa * sb);
    endfunction

    task automatic checkOutput(input string name, input logic [PW-1:0] actual, input logic [PW-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Model: advance on each rising edge from the applied inputs, then compare outputs on the falling edge.
    initial begin
        phase        = 0;
        nBits        = 0;
        calcLeft     = 0;
        sendIdx      = 0;
        strobePos    = 0;
        seenTimeouts = 0;
        strobe       = 1'b0;
        mA           = '0;
        mB           = '0;
        mProd        = '0;
        gotWord      = '0;
        expReady     = 1'b1;
        expValid     = 1'b0;
        expProd      = 1'b0;
        forever begin
            @(posedge i_clk);
            strobe = 1'b0;
            if (i_rst) begin
                phase    = 0;
                nBits    = 0;
                mA       = '0;
                mB       = '0;
                expReady = 1'b1;
                expValid = 1'b0;
                expProd  = 1'b0;
            end else if (i_en) begin
                case (phase)
                    0: if (i_valid) begin
                        mA[nBits] = i_din_a;
                        mB[nBits] = i_din_b;
                        nBits++;
                        if (nBits == W) begin
                            mProd    = refProduct(mA, mB);
                            nBits    = 0;
                            calcLeft = W + 1;
                            expReady = 1'b0;
                            phase    = 1;
                        end
                    end
                    1: begin
                        calcLeft--;
                        if (calcLeft == 0) begin
                            expValid = 1'b1;
                            phase    = 2;
                        end
                    end
                    2: if (i_ready) begin
                        expValid  = 1'b0;
                        expProd   = mProd[0];
                        sendIdx   = 1;
                        strobe    = 1'b1;
                        strobePos = 0;
                        phase     = 3;
                    end
                    default: begin
                        if (sendIdx == PW) begin
                            expProd  = 1'b0;
                            expReady = 1'b1;
                            phase    = 0;
                        end else begin
                            expProd   = mProd[sendIdx];
                            strobe    = 1'b1;
                            strobePos = sendIdx;
                            sendIdx++;
                        end
                    end
                endcase
            end
            @(negedge i_clk);
            checkOutput("o_ready", PW'(o_ready), PW'(expReady));
            checkOutput("o_valid", PW'(o_valid), PW'(expValid));
            checkOutput("o_prod", PW'(o_prod), PW'(expProd));
            if (strobe) begin
                gotWord[strobePos] = o_prod;
                if (strobePos == PW - 1) begin
                    checkOutput("product word", gotWord, mProd);
                    if (litValid) checkOutput("product literal", gotWord, litExp);
                end
            end
            if (timeoutCount != seenTimeouts) begin
                seenTimeouts = timeoutCount;
                compared++;
                mismatched++;
                $display("[TB] FAIL handshake timeout: got no response, expected o_valid/o_ready within 200 cycles");
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int gapPct, input int enOffPct);
        for (int i = 0; i < W; i++) begin
            bit done;
            done = 1'b0;
            while (!done) begin
                @(negedge i_clk);
                i_din_a = a[i];
                i_din_b = b[i];
                i_valid = ($urandom_range(99) >= gapPct);
                i_en    = ($urandom_range(99) >= enOffPct);
                @(posedge i_clk);
                done = i_valid && i_en;
            end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_en    = 1'b1;
    endtask

    task automatic drainWord(input int holdCycles, input int enOffPct);
        int cyc;
        i_ready = 1'b0;
        cyc = 0;
        while (o_valid !== 1'b1 && cyc < 200) begin
            i_en = ($urandom_range(99) >= enOffPct);
            i_valid = $urandom_range(1);
            @(negedge i_clk);
            cyc++;
        end
        i_valid = 1'b0;
        i_en = 1'b1;
        if (cyc >= 200) begin
            timeoutCount++;
            return;
        end
        repeat (holdCycles) @(negedge i_clk);
        i_ready = 1'b1;
        cyc = 0;
        while (o_ready !== 1'b1 && cyc < 200) begin
            @(negedge i_clk);
            i_en = ($urandom_range(99) >= enOffPct);
            if (o_valid !== 1'b1) i_ready = $urandom_range(1);
            cyc++;
        end
        if (cyc >= 200) timeoutCount++;
        i_ready = 1'b0;
        i_en    = 1'b1;
    endtask

    task automatic runWord(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] lit,
                           input int gapPct, input int enOffPct, input int holdCycles);
        litExp   = lit;
        litValid = 1'b1;
        applyStimulus(a, b, gapPct, enOffPct);
        drainWord(holdCycles, enOffPct);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        runWord(4'h7, 4'h3, 8'h15, 0, 0, 0);
        runWord(4'hF, 4'hF, LIT_FF, 0, 0, 0);
        runWord(4'h0, 4'hF, 8'h00, 0, 0, 0);
        runWord(4'h9, 4'hA, LIT_9A, 0, 0, 0);
        runWord(4'h8, 4'h7, LIT_87, 0, 0, 0);
        runWord(4'h9, 4'hA, LIT_9A, 40, 30, 2);
        runWord(4'h7, 4'h3, 8'h15, 0, 0, 20);

        // Abort a half-loaded word; reset must win over a simultaneous valid bit.
        litValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_din_a = 1'b1;
            i_din_b = 1'b1;
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        runWord(4'h3, 4'h5, 8'h0F, 0, 0, 0);

        // Abort during the Booth steps.
        litValid = 1'b0;
        applyStimulus(4'hB, 4'hD, 0, 0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        runWord(4'h6, 4'h6, 8'h24, 0, 0, 1);

        litValid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(15));
            rb = W'($urandom_range(15));
            applyStimulus(ra, rb, 25, 20);
            drainWord($urandom_range(3), 20);
        end

        repeat (4) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
